// File: rtl/transaction_timer_stats.sv
// transaction_timer_stats: latency statistics over timer measurements.
// Optional threshold/alarm logic is enabled by TT_STATS_THRESHOLD_EN.
module transaction_timer_stats #(
   parameter int REG_SIZE = 32,
   parameter int SUM_SIZE = 64,
   parameter int CNT_SIZE = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_valid,
   input  logic [REG_SIZE-1:0] i_time,
   input  logic                i_clear,
   input  logic                i_freeze,
`ifdef TT_STATS_THRESHOLD_EN
   input  logic [REG_SIZE-1:0] i_threshold,
   output logic [CNT_SIZE-1:0] o_exceed_count,
   output logic                o_alarm,
`endif
   output logic [CNT_SIZE-1:0] o_sample_count,
   output logic [REG_SIZE-1:0] o_min,
   output logic [REG_SIZE-1:0] o_max,
   output logic [SUM_SIZE-1:0] o_sum,
   output logic [REG_SIZE-1:0] o_last,
   output logic                o_overflow,
   output logic                o_updated
);

   logic                valid_d;
   logic                pending;
   logic [REG_SIZE-1:0] sample;
   logic                ev;
   logic [SUM_SIZE:0]   sum_wide;
   logic                sum_sat;
   logic                cnt_full;

   // a rise is only a new measurement when not frozen or being cleared
   always_comb begin
      ev       = i_valid & ~valid_d & ~i_freeze & ~i_clear;
      sum_wide = {1'b0, o_sum} + (SUM_SIZE+1)'(sample);
      sum_sat  = sum_wide[SUM_SIZE];
      cnt_full = &o_sample_count;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_d <= 1'b0;
      end else begin
         valid_d <= i_valid;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= 1'b0;
         sample  <= '0;
      end else begin
         pending <= ev;
         if (ev) begin
            sample <= i_time;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_sample_count <= '0;
         o_min          <= '1;
         o_max          <= '0;
         o_sum          <= '0;
         o_last         <= '0;
         o_overflow     <= 1'b0;
         o_updated      <= 1'b0;
      end else if (i_clear) begin
         o_sample_count <= '0;
         o_min          <= '1;
         o_max          <= '0;
         o_sum          <= '0;
         o_last         <= '0;
         o_overflow     <= 1'b0;
         o_updated      <= 1'b0;
      end else begin
         o_updated <= pending;
         if (pending) begin
            if (!cnt_full) begin
               o_sample_count <= o_sample_count + 1'b1;
            end
            if (sample < o_min) begin
               o_min <= sample;
            end
            if (sample > o_max) begin
               o_max <= sample;
            end
            o_last <= sample;
            // saturated sum pins at all-ones
            if (sum_sat) begin
               o_sum <= '1;
            end else begin
               o_sum <= sum_wide[SUM_SIZE-1:0];
            end
            if (sum_sat || cnt_full) begin
               o_overflow <= 1'b1;
            end
         end
      end
   end

`ifdef TT_STATS_THRESHOLD_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_exceed_count <= '0;
         o_alarm        <= 1'b0;
      end else if (i_clear) begin
         o_exceed_count <= '0;
         o_alarm        <= 1'b0;
      end else if (pending && (sample > i_threshold)) begin
         if (!(&o_exceed_count)) begin
            o_exceed_count <= o_exceed_count + 1'b1;
         end
         o_alarm <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_transaction_timer_stats.sv
// Scoreboard bench for transaction_timer_stats (SUM_SIZE=33, CNT_SIZE=4).
// Threshold checks are active when TT_STATS_THRESHOLD_EN is defined.
module tb_transaction_timer_stats;

   logic        clk;
   logic        rst_n;
   logic        i_valid;
   logic [31:0] i_time;
   logic        i_clear;
   logic        i_freeze;
   logic [3:0]  o_sample_count;
   logic [31:0] o_min;
   logic [31:0] o_max;
   logic [32:0] o_sum;
   logic [31:0] o_last;
   logic        o_overflow;
   logic        o_updated;
`ifdef TT_STATS_THRESHOLD_EN
   logic [31:0] i_threshold;
   logic [3:0]  o_exceed_count;
   logic        o_alarm;
`endif

   typedef struct {
      logic [3:0]  cnt;
      logic [31:0] mn;
      logic [31:0] mx;
      logic [32:0] sum;
      logic [31:0] last;
      logic        ovf;
      logic [3:0]  exc;
      logic        alm;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   transaction_timer_stats #(
      .REG_SIZE(32),
      .SUM_SIZE(33),
      .CNT_SIZE(4)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_valid        (i_valid),
      .i_time         (i_time),
      .i_clear        (i_clear),
      .i_freeze       (i_freeze),
`ifdef TT_STATS_THRESHOLD_EN
      .i_threshold    (i_threshold),
      .o_exceed_count (o_exceed_count),
      .o_alarm        (o_alarm),
`endif
      .o_sample_count (o_sample_count),
      .o_min          (o_min),
      .o_max          (o_max),
      .o_sum          (o_sum),
      .o_last         (o_last),
      .o_overflow     (o_overflow),
      .o_updated      (o_updated)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && o_updated) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_update: got update at cycle %0d want none", cyc);
         end else begin
            e = q.pop_front();
            chk("upd_cycle", 64'(cyc), 64'(e.cyc));
            chk("count", 64'(o_sample_count), 64'(e.cnt));
            chk("min", 64'(o_min), 64'(e.mn));
            chk("max", 64'(o_max), 64'(e.mx));
            chk("sum", 64'(o_sum), 64'(e.sum));
            chk("last", 64'(o_last), 64'(e.last));
            chk("overflow", 64'(o_overflow), 64'(e.ovf));
`ifdef TT_STATS_THRESHOLD_EN
            chk("exceed", 64'(o_exceed_count), 64'(e.exc));
            chk("alarm", 64'(o_alarm), 64'(e.alm));
`endif
         end
      end
   end

   task automatic push(input int c0, input logic [3:0] c,
                       input logic [31:0] mn, input logic [31:0] mx,
                       input logic [32:0] s, input logic [31:0] l,
                       input logic ovf, input logic [3:0] ex,
                       input logic al);
      exp_t e;
      e.cnt  = c;
      e.mn   = mn;
      e.mx   = mx;
      e.sum  = s;
      e.last = l;
      e.ovf  = ovf;
      e.exc  = ex;
      e.alm  = al;
      e.cyc  = c0 + 2;
      q.push_back(e);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 20) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d pending want 0", q.size());
         q.delete();
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [31:0] t, input logic [3:0] c,
                        input logic [31:0] mn, input logic [31:0] mx,
                        input logic [32:0] s, input logic ovf,
                        input logic [3:0] ex, input logic al);
      @(posedge clk);
      #1;
      i_time  = t;
      i_valid = 1'b1;
      push(cyc, c, mn, mx, s, t, ovf, ex, al);
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      drain();
   endtask

   task automatic clear();
      @(posedge clk);
      #1;
      i_clear = 1'b1;
      @(posedge clk);
      #1;
      i_clear = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_count"}, 64'(o_sample_count), 64'd0);
      chk({tag, "_min"}, 64'(o_min), 64'hFFFF_FFFF);
      chk({tag, "_max"}, 64'(o_max), 64'd0);
      chk({tag, "_sum"}, 64'(o_sum), 64'd0);
      chk({tag, "_last"}, 64'(o_last), 64'd0);
      chk({tag, "_ovf"}, 64'(o_overflow), 64'd0);
      chk({tag, "_upd"}, 64'(o_updated), 64'd0);
`ifdef TT_STATS_THRESHOLD_EN
      chk({tag, "_exceed"}, 64'(o_exceed_count), 64'd0);
      chk({tag, "_alarm"}, 64'(o_alarm), 64'd0);
`endif
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int c0;
      rst_n    = 1'b0;
      i_valid  = 1'b0;
      i_time   = '0;
      i_clear  = 1'b0;
      i_freeze = 1'b0;
`ifdef TT_STATS_THRESHOLD_EN
      i_threshold = 32'd100;
`endif
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_reset("reset");

      pulse(100, 1, 100, 100, 100, 0, 0, 0);
      pulse(40, 2, 40, 100, 140, 0, 0, 0);
      pulse(250, 3, 40, 250, 390, 0, 1, 1);

      clear();
      #1;
      chk_reset("clear");

      // level held high; time changes after the first cycle
      @(posedge clk);
      #1;
      i_time  = 7;
      i_valid = 1'b1;
      push(cyc, 1, 7, 7, 7, 7, 0, 0, 0);
      @(posedge clk);
      #1;
      i_time = 9;
      repeat (9) @(posedge clk);
      #1;
      i_valid = 1'b0;
      drain();
      chk("held_count", 64'(o_sample_count), 64'd1);

      pulse(20, 2, 7, 20, 27, 0, 0, 0);

      // clear coincides with a rise
      @(posedge clk);
      #1;
      i_time  = 500;
      i_valid = 1'b1;
      i_clear = 1'b1;
      @(posedge clk);
      #1;
      i_clear = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      i_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset("clr_rise");

      // clear lands on the pending stage-2 cycle
      @(posedge clk);
      #1;
      i_time  = 60;
      i_valid = 1'b1;
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      i_clear = 1'b1;
      @(posedge clk);
      #1;
      i_clear = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("clr_pend_count", 64'(o_sample_count), 64'd0);

      // frozen rise, freeze released while level still high
      @(posedge clk);
      #1;
      i_freeze = 1'b1;
      i_time   = 33;
      i_valid  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      i_freeze = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      i_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("freeze_count", 64'(o_sample_count), 64'd0);

      // freeze after the rise: sample in flight still commits
      @(posedge clk);
      #1;
      i_time  = 33;
      i_valid = 1'b1;
      push(cyc, 1, 33, 33, 33, 33, 0, 0, 0);
      @(posedge clk);
      #1;
      i_freeze = 1'b1;
      i_valid  = 1'b0;
      drain();
      i_freeze = 1'b0;

      pulse(50, 2, 33, 50, 83, 0, 0, 0);
      pulse(100, 3, 33, 100, 183, 0, 0, 0);
      pulse(101, 4, 33, 101, 284, 0, 1, 1);
      clear();
      #1;
      chk_reset("clr_thr");

      pulse(32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            33'h0_FFFF_FFFF, 0, 1, 1);
      pulse(32'hFFFF_FFFF, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            33'h1_FFFF_FFFE, 0, 2, 1);
      pulse(32'hFFFF_FFFF, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            33'h1_FFFF_FFFF, 1, 3, 1);
      clear();

      for (int k = 1; k <= 16; k++) begin
         pulse(1, (k > 15) ? 4'd15 : 4'(k), 1, 1, 33'(k),
               k == 16, 0, 0);
      end

      // async reset kills a pending sample; level high at release is a rise
      @(posedge clk);
      #1;
      i_time  = 5;
      i_valid = 1'b1;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk_reset("async");
      i_time = 77;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      c0 = cyc;
      push(c0, 1, 77, 77, 77, 77, 0, 0, 0);
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      drain();

      repeat (5) @(posedge clk);
      #1;
      chk("queue_empty", 64'(q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
